// File: rtl/restoring_divider_seq.sv
// restoring_divider_seq: sequential unsigned restoring divider, one quotient bit per cycle,
// valid/ready handshake on both the operand and the result side.
module restoring_divider_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(WIDTH);
    logic [1:0]       state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;
    // The partial remainder always stays below the divisor, so its top bit of the
    // WIDTH+1-bit trial is only the borrow and need not be stored.
    always_comb begin
        shifted  = {rem, q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs};
        fit      = !trial[WIDTH];
        rem_next = fit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], fit};
    end
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rem         <= '0;
            q           <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (divisor == '0) begin
                        state       <= DONE;
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else begin
                        state <= BUSY;
                        rem   <= '0;
                        q     <= dividend;
                        dvs   <= divisor;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    rem <= rem_next;
                    q   <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state       <= DONE;
                        quotient    <= q_next;
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_divider_seq.sv
// tb_restoring_divider_seq: directed vector table plus hand-written handshake, reset and
// random sequences for the 8-bit divider.
module tb_restoring_divider_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    int n_vec = 0;
    int n_err = 0;

    restoring_divider_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Issues one operation and returns once out_valid is seen (result left pending).
    task automatic op(input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] qo, output logic [7:0] ro,
                      output logic dz, output int lat);
        int g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 50);
        qo = quotient;
        ro = remainder;
        dz = div_by_zero;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t v[11];
        logic [7:0] qo, ro;
        logic dz;
        int lat;
        logic seen;
        v[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 8};
        v[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
        v[2]  = '{8'd3,   8'd10,  8'd0,   8'd3,   1'b0, 8};
        v[3]  = '{8'd200, 8'd200, 8'd1,   8'd0,   1'b0, 8};
        v[4]  = '{8'd0,   8'd9,   8'd0,   8'd0,   1'b0, 8};
        v[5]  = '{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 1};
        v[6]  = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 8};
        v[7]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
        v[8]  = '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0, 8};
        v[9]  = '{8'd255, 8'd2,   8'd127, 8'd1,   1'b0, 8};
        v[10] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 1};

        @(posedge clk); #1;
        chk("in_ready during reset", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset div_by_zero", div_by_zero, 0);

        for (int i = 0; i < 11; i++) begin
            op(v[i].a, v[i].b, qo, ro, dz, lat);
            chk($sformatf("v%0d quotient", i), qo, v[i].q);
            chk($sformatf("v%0d remainder", i), ro, v[i].r);
            chk($sformatf("v%0d div_by_zero", i), dz, v[i].dz);
            chk($sformatf("v%0d latency", i), lat, v[i].lat);
            pop();
            chk($sformatf("v%0d out_valid after pop", i), out_valid, 0);
        end

        // Backpressure: result held while out_ready low, new operands ignored.
        op(8'd77, 8'd4, qo, ro, dz, lat);
        chk("bp latency", lat, 8);
        for (int c = 0; c < 5; c++) begin
            dividend = 8'd200;
            divisor  = 8'd3;
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("bp%0d out_valid", c), out_valid, 1);
            chk($sformatf("bp%0d quotient", c), quotient, 19);
            chk($sformatf("bp%0d remainder", c), remainder, 1);
            chk($sformatf("bp%0d in_ready", c), in_ready, 0);
        end
        in_valid = 1'b0;
        pop();
        chk("bp out_valid after pop", out_valid, 0);
        chk("bp in_ready after pop", in_ready, 1);

        // Reset mid-operation abandons the result.
        dividend = 8'd250;
        divisor  = 8'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        chk("midrst no stale result", seen, 0);
        op(8'd9, 8'd2, qo, ro, dz, lat);
        chk("post-rst quotient", qo, 4);
        chk("post-rst remainder", ro, 1);
        chk("post-rst latency", lat, 8);
        pop();

        // Random operands with random consumer delay, checked against / and %.
        for (int k = 0; k < 200; k++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = (k % 16 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            op(a, b, qo, ro, dz, lat);
            if (b == 0) begin
                chk($sformatf("rnd%0d %0d/0 quotient", k, a), qo, 8'hFF);
                chk($sformatf("rnd%0d %0d/0 remainder", k, a), ro, a);
                chk($sformatf("rnd%0d dz", k), dz, 1);
                chk($sformatf("rnd%0d latency", k), lat, 1);
            end else begin
                chk($sformatf("rnd%0d %0d/%0d quotient", k, a, b), qo, a / b);
                chk($sformatf("rnd%0d %0d/%0d remainder", k, a, b), ro, a % b);
                chk($sformatf("rnd%0d dz", k), dz, 0);
                chk($sformatf("rnd%0d latency", k), lat, 8);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            chk($sformatf("rnd%0d held valid", k), out_valid, 1);
            pop();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
